intn_fp16_unpack_seq: RTL
=========================

Name: intn_fp16_unpack_seq

Overview:
- Streaming sequencer that accepts one packed word of INT_WIDTH-bit signed integers per input handshake.
- Converts the word to FP16 over several output beats, LANES elements per beat, through LANES instances of the existing intN_to_fp16 converter.
- Sits between a low-precision weight/activation stream and FP16 datapath consumers; provides full-throughput back-to-back word processing with valid/ready flow control on both sides.

Parameters:
- INT_WIDTH, 4, bits per packed signed integer; legal 1..4.
- IN_WIDTH, 64, width of packed input word; must be a multiple of INT_WIDTH.
- LANES, 4, FP16 results per output beat; NUM_ELEMS = IN_WIDTH/INT_WIDTH must be a multiple of LANES.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- in_data_i  in  IN_WIDTH  packed word; element i at bits [i*INT_WIDTH +: INT_WIDTH].
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  block can accept a word this cycle.
- out_data_o  out  16*LANES  FP16 results; lane l at bits [l*16 +: 16].
- out_valid_o  out  1  out_data_o valid.
- out_ready_i  in  1  consumer accepts beat.
- out_last_o  out  1  current beat is the final beat of its word.
- busy_o  out  1  a word is held (state CONV).

Behaviour:
- Derived constants: NUM_ELEMS = IN_WIDTH/INT_WIDTH; BEATS = NUM_ELEMS/LANES; beat counter width = max(1, $clog2(BEATS)).
- Elaboration-time assertions: INT_WIDTH in 1..4; IN_WIDTH % INT_WIDTH == 0; NUM_ELEMS % LANES == 0.
- Registers: word_q (IN_WIDTH), beat_q, state_q.
- Reset values: state IDLE, beat_q 0, word_q 0. Outputs at reset: out_valid_o=0, in_ready_o=1, out_last_o=0, busy_o=0.
- FSM states: IDLE, CONV.
- IDLE:
  - in_ready_o=1, out_valid_o=0.
  - On in_valid_i: word_q<=in_data_i, beat_q<=0, go to CONV.
- CONV:
  - out_valid_o=1; busy_o=1; out_last_o=(beat_q==BEATS-1).
  - Lane l converts element beat_q*LANES+l of word_q.
  - No handshake (out_ready_i=0): all state holds; out_data_o and out_last_o stay stable.
  - Handshake, not last beat: beat_q<=beat_q+1.
  - Handshake, last beat: in_ready_o=1 in this cycle only (combinational, equals out_ready_i). If in_valid_i, load the new word, beat_q<=0, stay in CONV (zero-bubble). Otherwise return to IDLE.
- in_ready_o is 0 in CONV except in the last-beat-handshake cycle. It never depends on in_valid_i.
- Latency: first beat is valid in the cycle after input acceptance. Sustained throughput is one beat per cycle, i.e. one word per BEATS cycles.
- BEATS==1: every CONV beat is last. Back-to-back words give one beat per cycle.
- Conversion semantics (per lane, fixed by intN_to_fp16):
  - Exact signed-integer-to-FP16 conversion; 0 -> 0x0000.
  - INT_WIDTH=1: bit 1 -> +1.0 (0x3C00), bit 0 -> -1.0 (0xBC00).
  - Most negative value converts exactly (int4 -8 -> 0xC800).
- out_data_o is combinational from word_q/beat_q. No output register, so no extra latency.
- Reset mid-operation: asserting rst_i immediately forces IDLE outputs. The held word and remaining beats are discarded; no partial beat is re-emitted after release.
- in_valid_i while in_ready_o=0: ignored. The upstream must hold data per valid/ready rules.

Decomposition:
- Package intn_fp16_pkg: FP16_WIDTH=16, FP16_POS_ONE=16'h3C00, FP16_NEG_ONE=16'hBC00, and the FSM state enum typedef (IDLE, CONV).
- Sub-module: the existing intN_to_fp16, generated LANES times with INT_WIDTH passed through.
- Lane slice selection (indexed part-select on word_q) stays inline.

Test Plan:
- Single word, INT_WIDTH=4, IN_WIDTH=64, LANES=4, in_data=64'h0000_0000_8F71_0000, out_ready=1:
  - In-accept cycle, then 4 beats in consecutive cycles.
  - Beat 1 lanes = {0x3C00 (1), 0x4700 (7), 0xBC00 (-1), 0xC800 (-8)}; beats 0, 2, 3 all 0x0000.
  - out_last only on beat 3; then IDLE.
- Backpressure: out_ready held low 5 cycles mid-word -> out_data/out_last stable, beat index frozen, in_ready=0; resumes without loss or duplication.
- Back-to-back: in_valid held high with 3 words, out_ready=1 -> 12 beats in 12 consecutive cycles; in_ready pulses exactly with each last-beat handshake.
- INT_WIDTH=1, IN_WIDTH=8, LANES=8, in_data=8'b1010_0101 -> single beat, lanes 0..7 = +1,-1,+1,-1,-1,+1,-1,+1 (0x3C00/0xBC00), out_last=1.
- Async reset asserted between clock edges during beat 2 -> out_valid drops and in_ready rises immediately. After release, a new word starts at beat 0.
- Idle stall: in_valid=0 for 10 cycles after IDLE -> out_valid=0, busy=0, in_ready=1 throughout.

Source files
------------

// File: rtl/intn_fp16_pkg.sv
// rtl/intn_fp16_pkg.sv - shared constants and FSM state type for the intN to FP16 unpacker
package intn_fp16_pkg;

    localparam int FP16_WIDTH = 16;
    localparam logic [FP16_WIDTH-1:0] FP16_POS_ONE = 16'h3C00;
    localparam logic [FP16_WIDTH-1:0] FP16_NEG_ONE = 16'hBC00;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } seq_state_e;

endpackage

// File: rtl/intN_to_fp16.sv
// rtl/intN_to_fp16.sv - exact conversion of one signed INT_WIDTH-bit integer to FP16
module intN_to_fp16
    import intn_fp16_pkg::*;
#(
    parameter int INT_WIDTH = 4
) (
    input  logic [INT_WIDTH-1:0]  int_i,
    output logic [FP16_WIDTH-1:0] fp16_o
);

    // One extra bit so the magnitude of the most negative value still fits.
    localparam int MW = INT_WIDTH + 1;

    logic          sign;
    logic [MW-1:0] mag;
    logic [3:0]    msb;
    logic [4:0]    expo;
    logic [9:0]    mant;

    // Sign/magnitude split, leading-one search and normalisation; all inputs are exact in FP16.
    always_comb begin
        fp16_o = '0;
        sign   = 1'b0;
        mag    = '0;
        msb    = '0;
        expo   = '0;
        mant   = '0;
        if (INT_WIDTH == 1) begin
            // A single bit encodes +1/-1, never zero.
            fp16_o = int_i[0] ? FP16_POS_ONE : FP16_NEG_ONE;
        end else begin
            sign = int_i[INT_WIDTH-1];
            mag  = {int_i[INT_WIDTH-1], int_i};
            if (sign) begin
                mag = ~mag + MW'(1);
            end
            for (int b = 0; b < MW; b++) begin
                if (mag[b]) begin
                    msb = 4'(b);
                end
            end
            expo = 5'd15 + {1'b0, msb};
            mant = 10'(11'(mag) << (4'd10 - msb));
            if (mag != '0) begin
                fp16_o = {sign, expo, mant};
            end
        end
    end

endmodule

// File: rtl/intn_fp16_unpack_seq.sv
// rtl/intn_fp16_unpack_seq.sv - streams one packed intN word out as FP16 beats of LANES lanes
module intn_fp16_unpack_seq
    import intn_fp16_pkg::*;
#(
    parameter int INT_WIDTH = 4,
    parameter int IN_WIDTH  = 64,
    parameter int LANES     = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [IN_WIDTH-1:0]         in_data_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic [FP16_WIDTH*LANES-1:0] out_data_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic                        out_last_o,
    output logic                        busy_o
);

    localparam int NUM_ELEMS = IN_WIDTH / INT_WIDTH;
    localparam int BEATS     = NUM_ELEMS / LANES;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LANE_BITS = LANES * INT_WIDTH;

    if (INT_WIDTH < 1 || INT_WIDTH > 4) begin : g_bad_int_width
        $error("INT_WIDTH must be in 1..4");
    end
    if (IN_WIDTH % INT_WIDTH != 0) begin : g_bad_in_width
        $error("IN_WIDTH must be a multiple of INT_WIDTH");
    end
    if (NUM_ELEMS % LANES != 0) begin : g_bad_lanes
        $error("IN_WIDTH/INT_WIDTH must be a multiple of LANES");
    end

    seq_state_e            state_q, state_d;
    logic [IN_WIDTH-1:0]   word_q, word_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  is_last;
    logic [LANE_BITS-1:0]  beat_word;

    assign is_last = (beat_q == BEAT_W'(BEATS - 1));

    // The current beat's elements, shifted down so lane l sits at a constant offset.
    assign beat_word = LANE_BITS'(word_q >> (32'(beat_q) * 32'(LANE_BITS)));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        intN_to_fp16 #(
            .INT_WIDTH(INT_WIDTH)
        ) u_conv (
            .int_i (beat_word[l*INT_WIDTH +: INT_WIDTH]),
            .fp16_o(out_data_o[l*FP16_WIDTH +: FP16_WIDTH])
        );
    end

    // State, held word and beat index; reset discards any word in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            word_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            beat_q  <= beat_d;
        end
    end

    // Next state and handshake outputs; input is only accepted in IDLE or on the last-beat handshake.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        beat_d      = beat_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    word_d  = in_data_i;
                    beat_d  = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
                out_last_o  = is_last;
                if (out_ready_i) begin
                    if (!is_last) begin
                        beat_d = beat_q + BEAT_W'(1);
                    end else begin
                        in_ready_o = 1'b1;
                        if (in_valid_i) begin
                            word_d = in_data_i;
                            beat_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
